cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
Iterative vectoring-mode CORDIC, the inverse of the rotation CORDIC. It takes a Cartesian vector (x,y) in Q2.14 and returns its gain-compensated magnitude and angle atan2(y,x) in Q3.13 radians. It uses the same operands_val/out_valid/ack handshake and 2-bit state export as the rotation block, so both can share benches and sit side by side in the datapath. Covers all four quadrants through a pre-rotation step.

Parameters:
ITER, 14, number of micro-rotations; legal range 1..14 (atan LUT has 14 entries).

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous, active-low reset.
x_in  input  16  signed Q2.14 x component.
y_in  input  16  signed Q2.14 y component.
operands_val  input  1  operands valid; captured when operands_rdy=1.
operands_rdy  output  1  high only in IDLE.
ack  input  1  consumer accepts result; honoured only in DONE.
mag_out  output  16  signed Q3.13 magnitude, always >=0.
theta_out  output  16  signed Q3.13 angle in radians, range [-25736, +25736].
out_valid  output  1  result valid; high only in DONE.
state  output  2  FSM state: 00 IDLE, 01 CALC, 10 SCALE, 11 DONE.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, mag_out=0, theta_out=0, out_valid=0, iteration counter=0, internal regs=0. Applies mid-operation; the in-flight result is discarded.
- IDLE: operands_rdy=1. On a Clk edge with operands_val=1, capture the operands and go to CALC (counter=0). operands_val=0 keeps IDLE.
- Capture / pre-rotation: internal x,y are 20-bit signed Q4.16 (sign-extend by 2, append 2 zero LSBs); z is 16-bit Q3.13.
  - x_in>=0: x0=x, y0=y, z0=0.
  - x_in<0, y_in>=0: x0=y, y0=-x, z0=+12868 (pi/2).
  - x_in<0, y_in<0: x0=-y, y0=x, z0=-12868.
  - x_in=y_in=0: set zero flag; the final result is forced to mag_out=0, theta_out=0.
- CALC: one micro-rotation per cycle, i=counter, using arithmetic shifts.
  - y>=0: x+=y>>>i, y-=x>>>i, z+=atan[i].
  - y<0: x-=y>>>i, y+=x>>>i, z-=atan[i].
  - Update x and y from the old values simultaneously.
  - atan LUT (Q3.13): 6434,3798,2007,1019,511,256,128,64,32,16,8,4,2,1.
  - After ITER cycles go to SCALE.
- SCALE (1 cycle): mag_out = (x*9949)>>>17, truncated to 16 bits (9949 = 1/K in Q2.14; 35-bit product). theta_out=z. If the zero flag is set, both are 0. Go to DONE.
- DONE: out_valid=1. mag_out and theta_out are held stable until ack=1, then go to IDLE on the next edge and out_valid drops.
- Latency: out_valid rises ITER+2 edges after the capture edge (16 with the default).
- mag_out and theta_out keep the last result after leaving DONE until the next SCALE.
- operands_val outside IDLE is ignored and no operands are queued. ack outside DONE is ignored.
- ack and operands_val both high in DONE: ack is taken, operands are not captured. The new request needs IDLE (one cycle later).
- Overflow: the largest input magnitude 2.83 gives internal x <= 4.66, which fits Q4.16. No saturation logic is required.
- Accuracy target: within +-4 LSB of the ideal Q3.13 value for ITER=14.

Test Plan:
1. (x,y)=(0x4000,0x0000), pulse operands_val, ack held low -> out_valid exactly 16 cycles after capture; mag_out=8192+-4, theta_out=0+-4.
2. (0x2D41,0x2D41) -> mag_out=8192+-4, theta_out=6434+-4.
3. (0xC000,0x0000) (second-quadrant path) -> theta_out=25736+-4, mag_out=8192+-4. Then (0x0000,0xC000) -> theta_out=-12868+-4.
4. (0xD2BF,0xD2BF) (third quadrant, -0.7071 each) -> theta_out=-19302+-4, mag_out=8192+-4. Then (0,0) -> mag_out=0, theta_out=0 exactly.
5. Handshake:
   - Hold ack low 20 cycles in DONE -> out_valid, state=11 and outputs stable.
   - Pulses on operands_val during CALC -> ignored; the result matches the first operands.
   - ack+operands_val high together in DONE -> IDLE next cycle, operands not captured.
6. Drop Rst_n during CALC (counter=5), asynchronously mid-cycle -> immediately state=00, out_valid=0, mag_out=theta_out=0. After release, a new (0x4000,0) transaction completes correctly.

Source files
------------

// File: rtl/cordic_vectoring_if.sv
// rtl/cordic_vectoring_if.sv - operand/result handshake bundle for the vectoring CORDIC
interface cordic_vectoring_if;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               operands_val;
    logic               operands_rdy;
    logic               ack;
    logic signed [15:0] mag_out;
    logic signed [15:0] theta_out;
    logic               out_valid;
    logic [1:0]         state;

    modport slave (
        input  x_in, y_in, operands_val, ack,
        output operands_rdy, mag_out, theta_out, out_valid, state
    );

    modport master (
        output x_in, y_in, operands_val, ack,
        input  operands_rdy, mag_out, theta_out, out_valid, state
    );
endinterface

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC returning magnitude and atan2 in Q3.13
module cordic_vectoring #(
    parameter int ITER = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    cordic_vectoring_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        SCALE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t             state_q, state_d;
    logic signed [19:0] x_q, y_q;
    logic signed [15:0] z_q;
    logic [3:0]         cnt_q;
    logic               zero_q;
    logic signed [15:0] mag_q, theta_q;

    logic signed [19:0] x_ext, y_ext, x_sh, y_sh, x_nx, y_nx;
    logic signed [15:0] z_nx, atan_i;
    logic signed [34:0] prod;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'sd6434;
            4'd1:    atan_lut = 16'sd3798;
            4'd2:    atan_lut = 16'sd2007;
            4'd3:    atan_lut = 16'sd1019;
            4'd4:    atan_lut = 16'sd511;
            4'd5:    atan_lut = 16'sd256;
            4'd6:    atan_lut = 16'sd128;
            4'd7:    atan_lut = 16'sd64;
            4'd8:    atan_lut = 16'sd32;
            4'd9:    atan_lut = 16'sd16;
            4'd10:   atan_lut = 16'sd8;
            4'd11:   atan_lut = 16'sd4;
            4'd12:   atan_lut = 16'sd2;
            4'd13:   atan_lut = 16'sd1;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.operands_val) state_d = CALC;
            CALC:    if (cnt_q == LAST)    state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (bus.ack)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Q2.14 -> Q4.16: two guard bits above, two fraction bits below.
    always_comb begin
        x_ext  = {{2{bus.x_in[15]}}, bus.x_in, 2'b00};
        y_ext  = {{2{bus.y_in[15]}}, bus.y_in, 2'b00};
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_i = atan_lut(cnt_q);
        if (!y_q[19]) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan_i;
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan_i;
        end
        // 9949 is 1/K in Q2.14; >>>17 lands the Q4.16 vector length in Q3.13.
        prod = $signed({{15{x_q[19]}}, x_q}) * 35'sd9949;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            theta_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.operands_val) begin
                    cnt_q  <= '0;
                    zero_q <= (bus.x_in == 16'sd0) && (bus.y_in == 16'sd0);
                    if (!bus.x_in[15]) begin
                        x_q <= x_ext;
                        y_q <= y_ext;
                        z_q <= 16'sd0;
                    end else if (!bus.y_in[15]) begin
                        x_q <= y_ext;
                        y_q <= -x_ext;
                        z_q <= 16'sd12868;
                    end else begin
                        x_q <= -y_ext;
                        y_q <= x_ext;
                        z_q <= -16'sd12868;
                    end
                end
                CALC: begin
                    x_q   <= x_nx;
                    y_q   <= y_nx;
                    z_q   <= z_nx;
                    cnt_q <= cnt_q + 4'd1;
                end
                SCALE: begin
                    mag_q   <= zero_q ? 16'sd0 : 16'(prod >>> 17);
                    theta_q <= zero_q ? 16'sd0 : z_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.operands_rdy = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.state        = state_q;
    assign bus.mag_out      = mag_q;
    assign bus.theta_out    = theta_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - directed bench with a real-arithmetic atan2/hypot reference
module tb_cordic_vectoring;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    cordic_vectoring_if ifc ();

    cordic_vectoring #(.ITER(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act - exp > tol || exp - act > tol) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    // Reference: ideal hypot and atan2 of the captured Q2.14 operands, expressed in Q3.13.
    int m_mag, m_theta;
    bit m_zero;
    always @(posedge clk) begin
        if (rst_n && ifc.operands_val && ifc.operands_rdy) begin
            real xr, yr;
            xr = $itor(ifc.x_in) / 16384.0;
            yr = $itor(ifc.y_in) / 16384.0;
            m_zero  <= (ifc.x_in == 0) && (ifc.y_in == 0);
            m_mag   <= rnd($sqrt(xr * xr + yr * yr) * 8192.0);
            m_theta <= ((ifc.x_in == 0) && (ifc.y_in == 0)) ? 0 : rnd($atan2(yr, xr) * 8192.0);
        end
    end

    bit prev_valid = 0;
    int prev_mag, prev_theta;
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid) begin
            chk("model_state", int'(ifc.state), 3, 0);
            chk("model_mag", int'(ifc.mag_out), m_zero ? 0 : m_mag, m_zero ? 0 : 4);
            chk("model_theta", int'(ifc.theta_out), m_zero ? 0 : m_theta, m_zero ? 0 : 4);
            if (prev_valid) begin
                chk("hold_mag", int'(ifc.mag_out), prev_mag, 0);
                chk("hold_theta", int'(ifc.theta_out), prev_theta, 0);
            end
        end
        prev_valid <= rst_n && ifc.out_valid;
        prev_mag   <= int'(ifc.mag_out);
        prev_theta <= int'(ifc.theta_out);
    end

    // Returns at posedge+1 of the first DONE cycle; lat counts edges from the capture edge inclusive.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input bit noise, output int lat);
        @(negedge clk);
        ifc.x_in = x;
        ifc.y_in = y;
        ifc.operands_val = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        ifc.operands_val = 1'b0;
        while (!ifc.out_valid && lat < 40) begin
            if (noise && lat >= 3 && lat <= 8) begin
                ifc.operands_val = lat[0];
                ifc.x_in = 16'($urandom);
                ifc.y_in = 16'($urandom);
            end else begin
                ifc.operands_val = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        ifc.operands_val = 1'b0;
    endtask

    task automatic release_done;
        ifc.ack = 1'b1;
        @(posedge clk);
        #1;
        ifc.ack = 1'b0;
        chk("ack_to_idle", int'(ifc.state), 0, 0);
    endtask

    task automatic txn(input string name, input logic [15:0] x, input logic [15:0] y,
                       input int e_mag, input int e_theta, input int tol);
        int lat;
        run_op(x, y, 1'b0, lat);
        chk({name, "_latency"}, lat, 16, 0);
        chk({name, "_mag"}, int'(ifc.mag_out), e_mag, tol);
        chk({name, "_theta"}, int'(ifc.theta_out), e_theta, tol);
        release_done();
    endtask

    initial begin
        int lat;
        int hold_mag, hold_theta;
        rst_n = 1'b0;
        ifc.x_in = '0;
        ifc.y_in = '0;
        ifc.operands_val = 1'b0;
        ifc.ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(ifc.state), 0, 0);
        chk("rst_valid", int'(ifc.out_valid), 0, 0);
        chk("rst_rdy", int'(ifc.operands_rdy), 1, 0);
        chk("rst_mag", int'(ifc.mag_out), 0, 0);
        chk("rst_theta", int'(ifc.theta_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unit x-axis vector, then hold ack low for 20 cycles.
        run_op(16'h4000, 16'h0000, 1'b0, lat);
        chk("t1_latency", lat, 16, 0);
        chk("t1_mag", int'(ifc.mag_out), 8192, 4);
        chk("t1_theta", int'(ifc.theta_out), 0, 4);
        hold_mag = int'(ifc.mag_out);
        hold_theta = int'(ifc.theta_out);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t1_hold_state", int'(ifc.state), 3, 0);
            chk("t1_hold_valid", int'(ifc.out_valid), 1, 0);
            chk("t1_hold_mag", int'(ifc.mag_out), hold_mag, 0);
            chk("t1_hold_theta", int'(ifc.theta_out), hold_theta, 0);
        end
        release_done();
        chk("t1_valid_drop", int'(ifc.out_valid), 0, 0);
        chk("t1_mag_kept", int'(ifc.mag_out), hold_mag, 0);

        txn("t2_diag", 16'h2D41, 16'h2D41, 8192, 6434, 4);
        txn("t3_negx", 16'hC000, 16'h0000, 8192, 25736, 4);
        txn("t3_negy", 16'h0000, 16'hC000, 8192, -12868, 4);
        txn("t4_q3", 16'hD2BF, 16'hD2BF, 8192, -19302, 4);
        txn("t4_zero", 16'h0000, 16'h0000, 0, 0, 0);
        txn("t4_q2", 16'hE000, 16'h2000, 5793, 19302, 4);

        // Operand pulses mid-CALC must not disturb the result.
        run_op(16'h2D41, 16'h2D41, 1'b1, lat);
        chk("t5_noise_latency", lat, 16, 0);
        chk("t5_noise_mag", int'(ifc.mag_out), 8192, 4);
        chk("t5_noise_theta", int'(ifc.theta_out), 6434, 4);

        // ack and operands_val together in DONE: ack wins, nothing captured.
        ifc.ack = 1'b1;
        ifc.operands_val = 1'b1;
        ifc.x_in = 16'h4000;
        ifc.y_in = 16'h0000;
        @(posedge clk);
        #1;
        chk("t5_both_state", int'(ifc.state), 0, 0);
        chk("t5_both_valid", int'(ifc.out_valid), 0, 0);
        ifc.ack = 1'b0;
        ifc.operands_val = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_not_captured", int'(ifc.state), 0, 0);

        // Asynchronous reset with the iteration counter at 5.
        @(negedge clk);
        ifc.x_in = 16'h2D41;
        ifc.y_in = 16'h2D41;
        ifc.operands_val = 1'b1;
        @(posedge clk);
        #1;
        ifc.operands_val = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", int'(ifc.state), 0, 0);
        chk("t6_rst_valid", int'(ifc.out_valid), 0, 0);
        chk("t6_rst_mag", int'(ifc.mag_out), 0, 0);
        chk("t6_rst_theta", int'(ifc.theta_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("t6_after", 16'h4000, 16'h0000, 8192, 0, 4);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
